boxcar_decimator: RTL and testbench
===================================

Name: boxcar_decimator

Overview:
- Downstream consumer of the signal switch output.
- Averages N = 2^log2_rate consecutive signed samples (accumulate-and-dump) and emits one decimated sample per block on an AXI4-Stream master port.
- Reduces the ADC-rate stream to the rate the DMA/host path can absorb; also suppresses noise before the vibrometer phase/FFT stages.

Parameters:
- DATA_WIDTH, 16, width of the signed input and output samples.
- MAX_LOG2_RATE, 8, largest supported log2 of the decimation factor; sets accumulator headroom.

Ports:
- SYS_aclk  input  1  system clock, all logic on rising edge.
- SYS_aresetn  input  1  asynchronous, active-low reset.
- log2_rate  input  4  requested log2 decimation factor; sampled only at block start.
- data_in  input  DATA_WIDTH  signed sample from the signal switch.
- data_in_valid  input  1  data_in is a new sample this cycle.
- M_AXIS_tdata  output  DATA_WIDTH  signed block average.
- M_AXIS_tvalid  output  1  tdata holds an unconsumed result.
- M_AXIS_tready  input  1  downstream accepts tdata.
- overflow  output  1  sticky: a result was overwritten before acceptance.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync release): accumulator=0, sample counter=0, active rate=0, M_AXIS_tdata=0, M_AXIS_tvalid=0, overflow=0. Reset mid-block discards the partial sum; no output is produced for it.
- Accumulator width ACC_W = DATA_WIDTH+MAX_LOG2_RATE, signed. Inputs are sign-extended. The sum cannot wrap.
- Active rate R is latched from log2_rate on the first valid sample of each block (counter==0). Values > MAX_LOG2_RATE clamp to MAX_LOG2_RATE. Changes mid-block take effect at the next block.
- Counter runs 0..2^R-1 and advances only on data_in_valid. Idle cycles (valid low) leave all state unchanged.
- On the valid cycle where counter==2^R-1:
  - Result = (acc + data_in) >>> R: arithmetic shift, truncation toward -inf, low DATA_WIDTH bits. The value always fits.
  - The result is registered into M_AXIS_tdata with tvalid=1 at the next edge, giving 1-cycle latency after the last sample.
  - The accumulator restarts at 0 and the counter at 0.
- R=0: pass-through; every valid sample appears one cycle later.
- Handshake: tvalid stays high and tdata stays stable until a cycle with tvalid&&tready. After that transfer, tvalid drops unless a new result loads on the same edge.
- Simultaneous accept and new result: the new result loads and tvalid stays 1. No overflow.
- New result while tvalid=1 and tready=0: the new result overwrites tdata, tvalid stays 1, and overflow sets to 1. Input is never stalled, because the ADC path has no backpressure.
- overflow is sticky until clear_overflow=1. If a set event and clear_overflow coincide, set wins.
- State machine, 2 states:
  - ACCUM: counter==0 or mid-block.
  - DUMP_PENDING: modelled by tvalid; the output register is independent of accumulation.

Decomposition:
- Shared include/package for the vibrometer stream stages:
  - DATA_WIDTH default.
  - MAX_LOG2_RATE.
  - ACC_W derivation as a constant function.
  - rate-clamp helper.
- One natural sub-module: axis_out_reg. This is the single-entry output register with tvalid/tready handshake and overflow detection; it is reusable by other decimating stages.
- Accumulator and counter stay in boxcar_decimator.

Test Plan:
- R=2, tready=1, inputs 14,14,14,14 every cycle -> tdata=14, tvalid pulses one cycle, 1 cycle after the 4th sample.
- R=2, inputs 1,2,3,4 -> 2. Inputs -1,-2,-3,-4 -> -3 (floor of -2.5).
- R=8, 256× 32767 -> 32767. 256× -32768 -> -32768. No wrap.
- R=0, inputs 14 then -29 with valid gaps -> outputs 14 then -29, each 1 cycle after input.
- R=1, tready=0, inputs 7,16,7,16 -> first result 11 held, then overwritten by 11, overflow=1. clear_overflow -> overflow=0. tready=1 -> single transfer.
- Reset mid-block (R=2, 2 samples in) -> no output. The next 4 samples of 5 -> output 5. A log2_rate change mid-block affects only the following block.

Source files
------------

// File: rtl/boxcar_decimator_pkg.sv
// Shared constants and helpers for the vibrometer stream stages.
// Holds the default widths, the accumulator width rule and the rate clamp.
package boxcar_decimator_pkg;

  localparam int DATA_WIDTH_DEFAULT    = 16;
  localparam int MAX_LOG2_RATE_DEFAULT = 8;
  localparam int RATE_W                = 4;

  // Summing 2^max_log2_rate samples needs max_log2_rate bits of headroom.
  function automatic int acc_width(input int data_width, input int max_log2_rate);
    return data_width + max_log2_rate;
  endfunction

  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] req,
                                                    input int                max_log2_rate);
    if (int'(req) > max_log2_rate) return RATE_W'(max_log2_rate);
    return req;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI4-Stream output register. A new result always loads, even when the
// previous one is still unconsumed; that case raises a sticky overflow flag.
module axis_out_reg
  import boxcar_decimator_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             tready_i,
  input  logic             clear_ovf_i,
  output logic [WIDTH-1:0] tdata_o,
  output logic             tvalid_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovf_d    = ovf_q;

    if (tvalid_q && tready_i) tvalid_d = 1'b0;
    if (clear_ovf_i)          ovf_d    = 1'b0;

    // Load is applied last so a coincident set beats clear and a new result beats the drop.
    if (load_i) begin
      tdata_d  = data_i;
      tvalid_d = 1'b1;
      if (tvalid_q && !tready_i) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tdata_o    = tdata_q;
  assign tvalid_o   = tvalid_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/boxcar_decimator.sv
// Accumulate-and-dump boxcar averager: sums 2^R signed samples, emits the floored mean
// on an AXI4-Stream master. Input is never stalled; late results overwrite and flag overflow.
module boxcar_decimator
  import boxcar_decimator_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int MAX_LOG2_RATE = MAX_LOG2_RATE_DEFAULT
) (
  input  logic                         SYS_aclk,
  input  logic                         SYS_aresetn,
  input  logic [RATE_W-1:0]            log2_rate,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic signed [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  input  logic                         M_AXIS_tready,
  output logic                         overflow,
  input  logic                         clear_overflow
);

  localparam int ACC_W = acc_width(DATA_WIDTH, MAX_LOG2_RATE);
  localparam int CNT_W = MAX_LOG2_RATE;

  logic signed [ACC_W-1:0]      acc_q, acc_d, sum;
  logic [CNT_W-1:0]             cnt_q, cnt_d, last_idx;
  logic [CNT_W:0]               block_len;
  logic [RATE_W-1:0]            rate_q, rate_d, eff_rate;
  logic                         block_done;
  logic signed [DATA_WIDTH-1:0] result;

  always_comb begin
    // The first sample of a block uses the freshly clamped request; later ones the latched rate.
    eff_rate   = (cnt_q == '0) ? clamp_rate(log2_rate, MAX_LOG2_RATE) : rate_q;
    block_len  = (CNT_W+1)'(1) << eff_rate;
    last_idx   = CNT_W'(block_len - 1'b1);
    sum        = acc_q + {{MAX_LOG2_RATE{data_in[DATA_WIDTH-1]}}, data_in};
    result     = DATA_WIDTH'(sum >>> eff_rate);
    block_done = data_in_valid && (cnt_q == last_idx);

    acc_d  = acc_q;
    cnt_d  = cnt_q;
    rate_d = rate_q;
    if (data_in_valid) begin
      rate_d = eff_rate;
      if (block_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      rate_q <= '0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
    end
  end

  axis_out_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_out (
    .clk        (SYS_aclk),
    .rst_n      (SYS_aresetn),
    .load_i     (block_done),
    .data_i     (result),
    .tready_i   (M_AXIS_tready),
    .clear_ovf_i(clear_overflow),
    .tdata_o    (M_AXIS_tdata),
    .tvalid_o   (M_AXIS_tvalid),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench for boxcar_decimator: expected block averages go into a queue as
// samples are driven and are compared whenever the DUT completes an AXI transfer.
module tb_boxcar_decimator;

  logic               clk;
  logic               rst_n;
  logic [3:0]         log2_rate;
  logic signed [15:0] data_in;
  logic               data_in_valid;
  logic signed [15:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               ovf;
  logic               clear_ovf;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];

  boxcar_decimator dut (
    .SYS_aclk      (clk),
    .SYS_aresetn   (rst_n),
    .log2_rate     (log2_rate),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tready (tready),
    .overflow      (ovf),
    .clear_overflow(clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    data_in       = 16'(v);
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  // Scoreboard: every accepted beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) check("unexpected_output", int'(tdata), 99999);
      else check("axis_data", int'(tdata), exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; log2_rate = 4'd2; data_in = '0; data_in_valid = 1'b0;
    tready = 1'b1; clear_ovf = 1'b0;
    #1;
    check("rst_tdata", int'(tdata), 0);
    check("rst_tvalid", int'(tvalid), 0);
    check("rst_ovf", int'(ovf), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // R=2 constant block: 1-cycle latency, single-cycle pulse
    exp_q.push_back(14);
    send(14); send(14); send(14);
    check("no_early_valid", int'(tvalid), 0);
    send(14);
    check("latency_valid", int'(tvalid), 1);
    check("latency_data", int'(tdata), 14);
    tick();
    check("pulse_drop", int'(tvalid), 0);

    // R=2 ramps, negative average floors toward -inf
    exp_q.push_back(2);
    send(1); send(2); send(3); send(4);
    exp_q.push_back(-3);
    send(-1); send(-2); send(-3); send(-4);
    tick();

    // R=8 full-scale extremes: no wrap
    log2_rate = 4'd8;
    exp_q.push_back(32767);
    for (int i = 0; i < 256; i++) send(32767);
    exp_q.push_back(-32768);
    for (int i = 0; i < 256; i++) send(-32768);
    tick();

    // R=0 pass-through with gaps, then back-to-back with accept + load each edge
    log2_rate = 4'd0;
    exp_q.push_back(14);
    send(14);
    check("r0_valid", int'(tvalid), 1);
    check("r0_data", int'(tdata), 14);
    tick(); tick();
    exp_q.push_back(-29);
    send(-29);
    check("r0_data_neg", int'(tdata), -29);
    tick();
    exp_q.push_back(5); exp_q.push_back(6); exp_q.push_back(7);
    send(5); send(6); send(7);
    check("accept_and_load_no_ovf", int'(ovf), 0);
    tick();

    // R=1 with tready low: hold, overwrite, overflow, clear, single transfer
    log2_rate = 4'd1;
    tready = 1'b0;
    send(7); send(16);
    check("hold_data", int'(tdata), 11);
    check("hold_ovf", int'(ovf), 0);
    tick(); tick();
    check("hold_valid", int'(tvalid), 1);
    send(7); send(16);
    check("overwrite_ovf", int'(ovf), 1);
    check("overwrite_data", int'(tdata), 11);
    send(3); send(5);
    check("overwrite_new_data", int'(tdata), 4);
    tick();
    check("ovf_sticky", int'(ovf), 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", int'(ovf), 0);
    check("valid_after_clear", int'(tvalid), 1);
    exp_q.push_back(4);
    tready = 1'b1;
    tick();
    check("single_transfer", int'(tvalid), 0);
    tick();

    // Overflow set coinciding with clear: set wins
    tready = 1'b0;
    send(1); send(1);
    send(2);
    clear_ovf = 1'b1;
    send(2);
    clear_ovf = 1'b0;
    check("set_beats_clear", int'(ovf), 1);
    check("set_beats_clear_data", int'(tdata), 2);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    exp_q.push_back(2);
    tready = 1'b1;
    tick();
    tick();

    // Reset mid-block discards the partial sum
    log2_rate = 4'd2;
    send(9); send(9);
    rst_n = 1'b0;
    tick();
    check("midreset_valid", int'(tvalid), 0);
    rst_n = 1'b1;
    tick();
    exp_q.push_back(5);
    send(5); send(5); send(5); send(5);
    check("after_reset_data", int'(tdata), 5);
    tick();

    // Rate change mid-block applies only to the next block
    log2_rate = 4'd1;
    send(2);
    log2_rate = 4'd2;
    exp_q.push_back(3);
    send(4);
    exp_q.push_back(2);
    send(1); send(1); send(1); send(5);
    tick();

    // Requests above the maximum clamp to R=8
    log2_rate = 4'd15;
    exp_q.push_back(100);
    for (int i = 0; i < 255; i++) send(100);
    check("clamp_not_early", int'(tvalid), 0);
    send(100);
    check("clamp_valid", int'(tvalid), 1);
    tick(); tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
